// File: rtl/uart_rx_cfg_if.sv
// Receive-side valid/ready stream carrying {frame_err, parity_err, data[7:0]}.
// master = receiver, slave = consumer (register block / DMA).
interface uart_rx_cfg_if;
  logic       o_Rx_Valid;
  logic [9:0] o_Rx_Data;
  logic       i_Rx_Ready;

  modport master (output o_Rx_Valid, output o_Rx_Data, input  i_Rx_Ready);
  modport slave  (input  o_Rx_Valid, input  o_Rx_Data, output i_Rx_Ready);
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5-8 data bits, none/even/odd parity, 1/2 stop) with a receive FIFO.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
module uart_rx_cfg #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             i_Clock,
  input  logic             rst_ni,
  input  logic             i_Rx_Serial,
  input  logic [CNT_W-1:0] i_Clks_Per_Bit,
  input  logic [1:0]       i_Data_Bits,
  input  logic [1:0]       i_Parity_Mode,
  input  logic             i_Two_Stop,
  input  logic             i_Clr_Overrun,
  output logic             o_Overrun,
  output logic             o_Busy,
  uart_rx_cfg_if.master    rx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cpb_q;
  logic [2:0]       bit_q, bit_d;
  logic             stop_q, stop_d, perr_q, perr_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       nbits_q, pmode_q;
  logic             two_q, cfg_ld;
  logic             line, smp, at_full, at_start, par_en, push;
  logic [9:0]       entry;
  logic [CNT_W-1:0] half, full;

  assign line   = sync_q[1];
  assign half   = (cpb_q - ONE) >> 1;
  assign full   = cpb_q - ONE;
  assign par_en = pmode_q[0] ^ pmode_q[1];

`ifdef UART_RX_MAJORITY_EN
  // Votes over line at count-1/count/count+1; the start point moves one clock later,
  // so every following sample point (counted from it) shifts by one as well.
  logic d1_q, d2_q;
  always_ff @(posedge i_Clock or negedge rst_ni)
    if (!rst_ni) begin
      d1_q <= 1'b1;
      d2_q <= 1'b1;
    end else begin
      d1_q <= line;
      d2_q <= d1_q;
    end
  assign smp      = (d2_q & d1_q) | (d2_q & line) | (d1_q & line);
  assign at_start = (cnt_q == half + ONE);
`else
  assign smp      = line;
  assign at_start = (cnt_q == half);
`endif
  assign at_full = (cnt_q == full);

  // State and datapath registers
  always_ff @(posedge i_Clock or negedge rst_ni)
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      perr_q  <= 1'b0;
      shift_q <= '0;
      cpb_q   <= '0;
      nbits_q <= '0;
      pmode_q <= '0;
      two_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_Rx_Serial};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      perr_q  <= perr_d;
      shift_q <= shift_d;
      if (cfg_ld) begin
        cpb_q   <= i_Clks_Per_Bit;
        nbits_q <= i_Data_Bits;
        pmode_q <= i_Parity_Mode;
        two_q   <= i_Two_Stop;
      end
    end

  // Next state; the counter restarts at every sample point, so bit periods stay exactly cpb
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    bit_d   = bit_q;
    stop_d  = stop_q;
    perr_d  = perr_q;
    shift_d = shift_q;
    cfg_ld  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!line) begin
          state_d = S_START;
          cfg_ld  = 1'b1;
          shift_d = '0;
          perr_d  = 1'b0;
          stop_d  = 1'b0;
        end
      end
      S_START:
        if (at_start) begin
          cnt_d   = '0;
          state_d = smp ? S_IDLE : S_DATA;
        end
      S_DATA:
        if (at_full) begin
          cnt_d          = '0;
          shift_d[bit_q] = smp;
          if (bit_q == ({1'b0, nbits_q} + 3'd4)) begin
            bit_d   = '0;
            state_d = par_en ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      S_PARITY:
        if (at_full) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ smp) != (pmode_q == 2'd2);
          state_d = S_STOP;
        end
      S_STOP:
        if (at_full) begin
          cnt_d = '0;
          if (!smp || !two_q || stop_q) state_d = line ? S_IDLE : S_BREAK;
          else                          stop_d  = 1'b1;
        end
      S_BREAK: begin
        cnt_d = '0;
        if (line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: a bad stop sample ends the frame at once and is folded into the pushed entry
  always_comb begin
    o_Busy = (state_q != S_IDLE);
    push   = (state_q == S_STOP) && at_full && (!smp || !two_q || stop_q);
    entry  = {!smp, perr_q, shift_q};
  end

  // Receive FIFO with an extra pointer bit for full/empty
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic empty, full_f, pop, wr, ovr_set;

  assign empty   = (wptr_q == rptr_q);
  assign full_f  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && rx.i_Rx_Ready;
  assign wr      = push && (!full_f || pop);
  assign ovr_set = push && full_f && !pop;

  assign rx.o_Rx_Valid = !empty;
  assign rx.o_Rx_Data  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge i_Clock or negedge rst_ni)
    if (!rst_ni) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      o_Overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr) begin
        mem_q[wptr_q[AW-1:0]] <= entry;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (ovr_set)            o_Overrun <= 1'b1;
      else if (i_Clr_Overrun) o_Overrun <= 1'b0;
    end
endmodule
